kamacore_stage_decode: RTL and testbench

KAMACORE_STAGE_DECODE -- requirements
Module: kamacore_stage_decode

---
 rtl/kamacore_pkg.sv | 68 ++++++
 rtl/kamacore_regfile_bypass.sv | 38 +++
 rtl/kamacore_stage_decode.sv | 129 ++++++++++++
 tb/tb_kamacore_stage_decode.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared RV32I decode definitions for the kamacore pipeline: opcodes,
// immediate formats, the per-opcode control bundle and the immediate generator.
package kamacore_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    imm_type_e imm_type;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      writes_rd;
    logic      is_load;
    logic      illegal;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_opcode(input logic [6:0] opc);
    dec_ctrl_t d;
    d          = '0;
    d.imm_type = IMM_NONE;
    case (opc)
      OPC_LOAD:   begin d.imm_type = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; end
      OPC_OP_IMM: begin d.imm_type = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
      OPC_JALR:   begin d.imm_type = IMM_I; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
      OPC_STORE:  begin d.imm_type = IMM_S; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
      OPC_BRANCH: begin d.imm_type = IMM_B; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
      OPC_OP:     begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
      OPC_LUI, OPC_AUIPC: begin d.imm_type = IMM_U; d.writes_rd = 1'b1; end
      OPC_JAL:    begin d.imm_type = IMM_J; d.writes_rd = 1'b1; end
      // Fence and system are legal but carry no immediate and no destination write.
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] ins);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/kamacore_regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hard-wired to zero, optional same-cycle writeback forwarding.
module kamacore_regfile_bypass #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  parameter  int BYPASS_EN = 1,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [RA_W-1:0] i_ra1,
  input  logic [RA_W-1:0] i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic            w_byp1;
  logic            w_byp2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign w_byp1 = (BYPASS_EN != 0) && i_we && (i_wa == i_ra1);
  assign w_byp2 = (BYPASS_EN != 0) && i_we && (i_wa == i_ra2);

  assign o_rd1 = (i_ra1 == '0) ? '0 : (w_byp1 ? i_wd : r_regs[i_ra1]);
  assign o_rd2 = (i_ra2 == '0) ? '0 : (w_byp2 ? i_wd : r_regs[i_ra2]);

endmodule

// File: rtl/kamacore_stage_decode.sv
// RV32I decode stage: one-deep registered bundle with valid/ready handshake,
// load-use interlock, flush, and register-file read with writeback forwarding.
module kamacore_stage_decode
  import kamacore_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  parameter  int BYPASS_EN = 1,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_rd_a,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic            out_illegal,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd_a,
  input  logic [XLEN-1:0] wb_rd_data
);

  dec_ctrl_t          w_ctrl;
  logic [RA_W-1:0]    w_rs1_a;
  logic [RA_W-1:0]    w_rs2_a;
  logic [RA_W-1:0]    w_rd_a;
  logic [XLEN-1:0]    w_rs1_data;
  logic [XLEN-1:0]    w_rs2_data;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_hazard;
  logic               w_accept;

  logic               r_vld_p1;
  logic [XLEN-1:0]    r_pc_p1;
  logic [31:0]        r_instr_p1;
  logic [XLEN-1:0]    r_rs1_p1;
  logic [XLEN-1:0]    r_rs2_p1;
  logic [XLEN-1:0]    r_imm_p1;
  logic [RA_W-1:0]    r_rd_a_p1;
  logic               r_rd_we_p1;
  logic               r_is_load_p1;
  logic               r_illegal_p1;

  assign w_ctrl  = decode_opcode(in_instr[6:0]);
  assign w_rs1_a = in_instr[15 +: RA_W];
  assign w_rs2_a = in_instr[20 +: RA_W];
  assign w_rd_a  = in_instr[7 +: RA_W];
  assign w_imm32 = gen_imm(w_ctrl.imm_type, in_instr);
  assign w_imm   = XLEN'(w_imm32);

  kamacore_regfile_bypass #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_we),
    .i_wa  (wb_rd_a),
    .i_wd  (wb_rd_data),
    .i_ra1 (w_rs1_a),
    .i_ra2 (w_rs2_a),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data)
  );

  // A load in the output slot cannot forward its data yet, so any consumer waits.
  assign w_hazard = r_vld_p1 && r_is_load_p1 && (r_rd_a_p1 != '0) &&
                    ((w_ctrl.uses_rs1 && (w_rs1_a == r_rd_a_p1)) ||
                     (w_ctrl.uses_rs2 && (w_rs2_a == r_rd_a_p1)));

  assign in_ready = (~r_vld_p1 | out_ready) & ~w_hazard & ~flush & ~rst;
  assign w_accept = in_valid & in_ready;

  // Stage 0 -> stage 1: decoded bundle register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_pc_p1      <= '0;
      r_instr_p1   <= '0;
      r_rs1_p1     <= '0;
      r_rs2_p1     <= '0;
      r_imm_p1     <= '0;
      r_rd_a_p1    <= '0;
      r_rd_we_p1   <= 1'b0;
      r_is_load_p1 <= 1'b0;
      r_illegal_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_pc_p1      <= in_pc;
      r_instr_p1   <= in_instr;
      r_rs1_p1     <= w_rs1_data;
      r_rs2_p1     <= w_rs2_data;
      r_imm_p1     <= w_imm;
      r_rd_a_p1    <= w_rd_a;
      r_rd_we_p1   <= w_ctrl.writes_rd && (w_rd_a != '0);
      r_is_load_p1 <= w_ctrl.is_load;
      r_illegal_p1 <= w_ctrl.illegal;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_pc       = r_pc_p1;
  assign out_instr    = r_instr_p1;
  assign out_rs1_data = r_rs1_p1;
  assign out_rs2_data = r_rs2_p1;
  assign out_imm      = r_imm_p1;
  assign out_rd_a     = r_rd_a_p1;
  assign out_rd_we    = r_rd_we_p1;
  assign out_is_load  = r_is_load_p1;
  assign out_illegal  = r_illegal_p1;

endmodule

// File: tb/tb_kamacore_stage_decode.sv
// Bench for kamacore_stage_decode: directed scenarios plus randomized traffic
// against a behavioural model, with a forwarding and a non-forwarding instance.
module tb_kamacore_stage_decode;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_FENCE = 7'b0001111, T_OPIMM = 7'b0010011,
                         T_AUIPC = 7'b0010111, T_STORE = 7'b0100011, T_OP = 7'b0110011,
                         T_LUI = 7'b0110111, T_BRANCH = 7'b1100011, T_JALR = 7'b1100111,
                         T_JAL = 7'b1101111, T_SYSTEM = 7'b1110011;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0]     in_instr = '0;
  logic            out_ready = 1'b0;
  logic            flush = 1'b0;
  logic            wb_we = 1'b0;
  logic [RA_W-1:0] wb_rd_a = '0;
  logic [XLEN-1:0] wb_rd_data = '0;

  logic            in_ready, out_valid, out_rd_we, out_is_load, out_illegal;
  logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [31:0]     out_instr;
  logic [RA_W-1:0] out_rd_a;

  logic            nb_in_ready, nb_out_valid, nb_out_rd_we, nb_out_is_load, nb_out_illegal;
  logic [XLEN-1:0] nb_out_pc, nb_out_rs1_data, nb_out_rs2_data, nb_out_imm;
  logic [31:0]     nb_out_instr;
  logic [RA_W-1:0] nb_out_rd_a;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  kamacore_stage_decode #(.XLEN(XLEN), .REG_COUNT(32), .BYPASS_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd_a(out_rd_a), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .out_illegal(out_illegal), .flush(flush), .wb_we(wb_we), .wb_rd_a(wb_rd_a),
    .wb_rd_data(wb_rd_data));

  kamacore_stage_decode #(.XLEN(XLEN), .REG_COUNT(32), .BYPASS_EN(0)) u_dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .out_valid(nb_out_valid), .out_ready(out_ready), .out_pc(nb_out_pc),
    .out_instr(nb_out_instr), .out_rs1_data(nb_out_rs1_data), .out_rs2_data(nb_out_rs2_data),
    .out_imm(nb_out_imm), .out_rd_a(nb_out_rd_a), .out_rd_we(nb_out_rd_we),
    .out_is_load(nb_out_is_load), .out_illegal(nb_out_illegal), .flush(flush), .wb_we(wb_we),
    .wb_rd_a(wb_rd_a), .wb_rd_data(wb_rd_data));

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  logic        m_valid, m_rd_we, m_is_load, m_illegal;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_rs1_nb, m_rs2_nb, m_imm;
  logic [4:0]  m_rd;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {T_LOAD, T_FENCE, T_OPIMM, T_AUIPC, T_STORE, T_OP, T_LUI,
                      T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {T_LOAD, T_OPIMM, T_JALR, T_STORE, T_BRANCH, T_OP};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {T_STORE, T_BRANCH, T_OP};
  endfunction

  function automatic bit has_dest(input logic [6:0] op);
    return op inside {T_OP, T_OPIMM, T_LOAD, T_JALR, T_LUI, T_AUIPC, T_JAL};
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    int s;
    s = $signed(ins);
    case (ins[6:0])
      T_LOAD, T_OPIMM, T_JALR: return 32'(s >>> 20);
      T_STORE:  return 32'(((s >>> 25) << 5) | int'(ins[11:7]));
      T_BRANCH: return 32'(((s >>> 31) << 12) | (int'(ins[7]) << 11) |
                           (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
      T_LUI, T_AUIPC: return ins & 32'hFFFFF000;
      T_JAL:    return 32'(((s >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                           (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wb_we && wb_rd_a == a) return wb_rd_data;
    return m_rf[a];
  endfunction

  function automatic bit model_hazard(input logic [31:0] ins);
    if (!(m_valid && m_is_load && m_rd != 5'd0)) return 1'b0;
    return (reads_rs1(ins[6:0]) && ins[19:15] == m_rd) ||
           (reads_rs2(ins[6:0]) && ins[24:20] == m_rd);
  endfunction

  function automatic bit exp_in_ready();
    return (!m_valid || out_ready) && !model_hazard(in_instr) && !flush && !rst;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0; m_rs1_nb = 0; m_rs2_nb = 0;
      m_imm = 0; m_rd = 0; m_rd_we = 0; m_is_load = 0; m_illegal = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      bit acc;
      acc = in_valid && exp_in_ready();
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid   = 1;
        m_pc      = in_pc;
        m_instr   = in_instr;
        m_rs1     = rf_read(in_instr[19:15], 1'b1);
        m_rs2     = rf_read(in_instr[24:20], 1'b1);
        m_rs1_nb  = rf_read(in_instr[19:15], 1'b0);
        m_rs2_nb  = rf_read(in_instr[24:20], 1'b0);
        m_imm     = model_imm(in_instr);
        m_rd      = in_instr[11:7];
        m_is_load = (in_instr[6:0] == T_LOAD);
        m_illegal = !is_legal(in_instr[6:0]);
        m_rd_we   = has_dest(in_instr[6:0]) && in_instr[11:7] != 5'd0;
      end else if (out_ready || !m_valid) m_valid = 0;
      if (wb_we && wb_rd_a != 5'd0) m_rf[wb_rd_a] = wb_rd_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
      chk("nb_in_ready", 32'(nb_in_ready), 32'(exp_in_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("nb_out_valid", 32'(nb_out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", out_instr, m_instr);
        chk("out_rs1_data", out_rs1_data, m_rs1);
        chk("out_rs2_data", out_rs2_data, m_rs2);
        chk("nb_out_rs1_data", nb_out_rs1_data, m_rs1_nb);
        chk("nb_out_rs2_data", nb_out_rs2_data, m_rs2_nb);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd_a", 32'(out_rd_a), 32'(m_rd));
        chk("out_rd_we", 32'(out_rd_we), 32'(m_rd_we));
        chk("out_is_load", 32'(out_is_load), 32'(m_is_load));
        chk("out_illegal", 32'(out_illegal), 32'(m_illegal));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_rs1"}, out_rs1_data, 0);
    chk({tag, "_rs2"}, out_rs2_data, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_rd_a"}, 32'(out_rd_a), 0);
    chk({tag, "_rd_we"}, 32'(out_rd_we), 0);
    chk({tag, "_is_load"}, 32'(out_is_load), 0);
    chk({tag, "_illegal"}, 32'(out_illegal), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] ins;
    int k;
    ops = '{T_LOAD, T_FENCE, T_OPIMM, T_AUIPC, T_STORE, T_OP, T_LUI, T_BRANCH,
            T_JALR, T_JAL, T_SYSTEM, 7'b1111111};
    ins = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) ins[6:0] = ops[k];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk_all_zero("reset");
    @(negedge clk);
    chk_all_zero("reset_hold");
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("first_ready_after_reset", 32'(in_ready), 1);

    // writeback x5 then addi x6,x5,-1
    cyc(); wb_we = 1; wb_rd_a = 5; wb_rd_data = 32'h1234;
    cyc(); wb_we = 0; in_valid = 1; in_pc = 32'h100; in_instr = 32'hFFF28313;
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_rs1", out_rs1_data, 32'h1234);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(out_rd_a), 6);
    chk("addi_rd_we", 32'(out_rd_we), 1);

    // same-cycle writeback x7 with add x8,x7,x0
    cyc(); wb_we = 1; wb_rd_a = 7; wb_rd_data = 32'hAA; in_valid = 1; in_instr = 32'h00038433;
    cyc(); wb_we = 0; in_valid = 0;
    @(negedge clk);
    chk("bypass_rs1", out_rs1_data, 32'hAA);
    chk("nobypass_rs1", nb_out_rs1_data, 32'h0);

    // load-use: lw x3,0(x1) then add x4,x3,x2
    cyc(); in_valid = 1; in_instr = 32'h0000A183;
    cyc(); in_instr = 32'h00218233;
    @(negedge clk);
    chk("loaduse_stall_ready", 32'(in_ready), 0);
    chk("loaduse_lw_out", 32'(out_is_load), 1);
    cyc();
    @(negedge clk);
    chk("loaduse_bubble", 32'(out_valid), 0);
    chk("loaduse_ready_after", 32'(in_ready), 1);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("loaduse_add_out", out_instr, 32'h00218233);
    chk("loaduse_add_rd", 32'(out_rd_a), 4);
    // lw x0 then add x4,x0,x2: no bubble
    cyc(); in_valid = 1; in_instr = 32'h0000A003;
    cyc(); in_instr = 32'h00200233;
    @(negedge clk);
    chk("x0_load_no_stall", 32'(in_ready), 1);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("x0_load_add_out", out_instr, 32'h00200233);

    // downstream stall for 3 cycles
    cyc(); out_ready = 0; in_valid = 1; in_instr = 32'h00500493;
    cyc(); in_instr = 32'h00700513;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_instr", out_instr, 32'h00500493);
      cyc();
    end
    out_ready = 1;
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("stall_release_instr", out_instr, 32'h00700513);

    // flush during stall with valid held
    cyc(); out_ready = 0; in_valid = 1; in_instr = 32'h00500493;
    cyc(); in_instr = 32'h00700513;
    cyc(); flush = 1;
    cyc(); flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("flush_clears_valid", 32'(out_valid), 0);
    cyc();
    @(negedge clk);
    chk("flush_no_emit", 32'(out_valid), 0);

    // illegal opcode, then async reset mid-stall
    cyc(); in_valid = 1; in_instr = 32'hFFFFFFFF;
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("illegal_flag", 32'(out_illegal), 1);
    chk("illegal_rd_we", 32'(out_rd_we), 0);
    chk("illegal_imm", out_imm, 0);
    #1 out_ready = 0; in_valid = 1; in_instr = 32'h00500493;
    #1 rst = 1;
    #1 chk_all_zero("midreset");
    cyc(); rst = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("midreset_no_transfer", 32'(out_valid), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      wb_we      = $urandom_range(0, 1) == 1;
      wb_rd_a    = 5'($urandom_range(0, 3));
      wb_rd_data = $urandom;
      in_pc      = $urandom;
      in_instr   = rand_instr();
    end
    cyc();
    in_valid = 0; flush = 0; wb_we = 0;
    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1);
  end

endmodule
